nonce_collector: RTL and testbench
==================================

# nonce_collector

Downstream stage of the miner core. It captures each `(nonce_found, nonce_out)` hit the miner reports into a small FIFO, then presents the hits to the host-side register/AXI logic over a valid/ready handshake. It masks the miner's pipeline-fill window after every job restart, counts hits and records overflow, so the host never misses or double-reads a result.

## Interface
Parameters:
- `DEPTH`, 4 — result FIFO entries; power of two, at least 2.
- `BLANK`, 16 — cycles after `job_start` during which `hit` is ignored; at least 1, at most 255.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `job_start`  in  1  — one-cycle pulse, the same pulse that restarts the miner; synchronous flush.
- `hit`  in  1  — miner `nonce_found`, sampled every cycle.
- `hit_nonce`  in  32  — miner `nonce_out`, valid when `hit`=1.
- `res_valid`  out  1  — FIFO head is valid.
- `res_nonce`  out  32  — FIFO head nonce.
- `res_ready`  in  1  — consumer accepts the head when `res_valid & res_ready`.
- `level`  out  `$clog2(DEPTH)+1`  — FIFO occupancy.
- `hit_count`  out  32  — hits accepted since the last flush (stored + dropped).
- `overflow`  out  1  — sticky; a hit was dropped because the FIFO was full.
- `blanking`  out  1  — high while the blank counter is non-zero.

## Operation
- **States** (derived from the blank counter `bcnt`):
  - BLANK when `bcnt`≠0.
  - RUN when `bcnt`=0.
- **On `job_start`:**
  - Load `bcnt`←`BLANK`.
  - Empty the FIFO (pointers to 0).
  - Clear `hit_count` and `overflow`.
  - Discard any `hit` or pop in the same cycle.
  - A `job_start` during BLANK reloads `bcnt`.
- **BLANK:** `bcnt` decrements each cycle; `hit` is ignored and not counted. The transition to RUN occurs on the edge where `bcnt` goes 1→0. The first sampled hit is in the cycle where `bcnt`=0.
- **RUN, `hit`=1 (accepted hit):**
  - `hit_count` increments, saturating at 0xFFFFFFFF.
  - If the FIFO is not full, or a pop occurs in the same cycle, push `hit_nonce`.
  - Otherwise drop the hit and set `overflow`.
- **Pop:** occurs when `res_valid & res_ready`. Popping while empty has no effect. Push and pop in the same cycle leave `level` unchanged.
- **Pointers:** `$clog2(DEPTH)`-bit read/write pointers wrap modulo `DEPTH`. `level` is kept as an explicit counter. Full when `level`=`DEPTH`, empty when `level`=0.
- **Head output:** `res_nonce` shows the head entry when `res_valid`=1. When `res_valid`=0 it holds its last value, which is 0 after reset.
- **Reset values:**
  - `res_valid`=0, `res_nonce`=0, `level`=0
  - `hit_count`=0, `overflow`=0
  - `blanking`=0; `bcnt`=0, so the block comes out of reset in RUN.

## Timing
- **Hit to output:** a hit sampled at edge N gives `res_valid`=1 after edge N (registered, 1-cycle latency) when the FIFO was empty.
- **Counters:** `hit_count`, `level` and `overflow` update at the same edge as the push.
- **Back-to-back pops:** `res_valid` stays high across consecutive pops while entries remain, so back-to-back pops sustain one per cycle.
- **`res_ready`:** may be held high permanently. `res_valid` never depends combinationally on `res_ready`.
- **`job_start` and `reset`:** `job_start` takes effect at its edge, with `res_valid`=0 the following cycle. An asynchronous `reset` mid-operation forces all outputs to their reset values immediately.
- **`blanking`:** equals (`bcnt`≠0), registered.

## Structure
- **Shared package `miner_pkg`:**
  - `NONCE_W`=32.
  - `BLANK_DEFAULT`, kept in step with miner pipeline depth; `BLANK` must be at least the miner's `reset` to first-valid-compare latency.
- **One sub-module `nonce_fifo`:**
  - Parameterised synchronous FIFO with `push`, `pop`, `flush`, `level` and head data.
  - Handles the wrap, full/empty and simultaneous push/pop rules.
- **Top level:** `nonce_collector` contains only the blank counter, hit counter, overflow flag and the push/pop gating.

## Test plan
- **Reset then hits:** reset, then hits with nonces 0x10, 0x20, 0x30 on consecutive cycles, `res_ready`=0 → `level`=3, `res_valid`=1, `res_nonce`=0x10, `hit_count`=3.
- **Overflow:** `DEPTH`=4, six hits 0xA0..0xA5 with `res_ready`=0 → `level`=4, `overflow`=1, `hit_count`=6. Draining yields 0xA0..0xA3 in order, then `res_valid`=0.
- **Blanking window:** `job_start`, then `hit`=1 with nonce 0x55 held for 20 cycles (`BLANK`=16):
  - No pushes during the 16 blank cycles.
  - Pushes start in the cycle `bcnt`=0.
  - `blanking` is high for exactly 16 cycles.
- **Full with simultaneous push and pop:** FIFO full, push 0xBB with `res_ready`=1 → head advances, `level` stays 4, `overflow` stays 0, 0xBB is read last.
- **Pointer wrap:** stream 3×`DEPTH` hits with `res_ready`=1 → every nonce is read exactly once and in order, and `level` never exceeds 1.
- **Flush and mid-operation reset:**
  - `job_start` coincident with a hit while 2 entries are stored → `level`=0, `hit_count`=0, the coincident hit is discarded.
  - Asserting `reset` mid-stream → all outputs go to their reset values asynchronously.

Source files
------------

// File: rtl/miner_pkg.sv
// miner_pkg: shared widths, defaults and helpers for the miner result path
package miner_pkg;

    localparam int NONCE_W       = 32;
    // Must cover the miner's reset to first-valid-compare latency; track pipeline depth.
    localparam int BLANK_DEFAULT = 16;
    localparam int BCNT_W        = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } coll_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous result FIFO with flush, explicit level and registered head
module nonce_fifo
    import miner_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = NONCE_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [LW-1:0] level_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [W-1:0]  head_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [LW-1:0] level_q, level_d, remain;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign valid_o = (level_q != '0);
    assign level_o = level_q;
    assign head_o  = head_q;

    // Next pointers/level; the head register follows the entry that will be at the front
    // and keeps its previous value whenever the FIFO ends up empty or is flushed.
    always_comb begin
        do_pop  = pop_i & ~flush_i & valid_o;
        do_push = push_i & ~flush_i & (~full_o | do_pop);
        remain  = level_q - LW'(do_pop);
        rptr_d  = flush_i ? '0 : rptr_q + AW'(do_pop);
        wptr_d  = flush_i ? '0 : wptr_q + AW'(do_push);
        level_d = flush_i ? '0 : remain + LW'(do_push);
        head_d  = flush_i ? head_q :
                  (remain != '0) ? mem_q[rptr_d] :
                  (do_push ? din_i : head_q);
    end

    // Control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            head_q  <= head_d;
        end
    end

    // Storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/nonce_collector.sv
// nonce_collector: captures miner hits into a FIFO, blanks after job restarts, counts hits
module nonce_collector
    import miner_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int BLANK = BLANK_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_start,
    input  logic                   hit,
    input  logic [NONCE_W-1:0]     hit_nonce,
    output logic                   res_valid,
    output logic [NONCE_W-1:0]     res_nonce,
    input  logic                   res_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [31:0]            hit_count,
    output logic                   overflow,
    output logic                   blanking
);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic              overflow_q, overflow_d;
    logic              full, accept, push, pop;
    coll_state_e       state;

    assign state     = (bcnt_q != '0) ? ST_BLANK : ST_RUN;
    assign hit_count = hit_count_q;
    assign overflow  = overflow_q;
    assign blanking  = (state == ST_BLANK);

    // Push/pop gating; a job_start swallows any same-cycle hit or pop
    always_comb begin
        pop    = res_valid & res_ready & ~job_start;
        accept = hit & ~job_start & (state == ST_RUN);
        push   = accept & (~full | pop);
    end

    // Next blank counter, hit counter and sticky overflow
    always_comb begin
        bcnt_d      = job_start ? BCNT_W'(BLANK) :
                      (state == ST_BLANK) ? bcnt_q - BCNT_W'(1) : bcnt_q;
        hit_count_d = job_start ? '0 : (accept ? sat_inc(hit_count_q) : hit_count_q);
        overflow_d  = job_start ? 1'b0 : (overflow_q | (accept & ~push));
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt_q      <= '0;
            hit_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            hit_count_q <= hit_count_d;
            overflow_q  <= overflow_d;
        end
    end

    nonce_fifo #(
        .DEPTH(DEPTH),
        .W    (NONCE_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush_i(job_start),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (hit_nonce),
        .level_o(level),
        .valid_o(res_valid),
        .full_o (full),
        .head_o (res_nonce)
    );

endmodule

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector: directed stimulus checked against a queue-based model every cycle
module tb_nonce_collector;

    localparam int DEPTH = 4;
    localparam int BLANK = 16;

    logic        clk = 1'b0;
    logic        reset, job_start, hit, res_ready;
    logic [31:0] hit_nonce;
    logic        res_valid, overflow, blanking;
    logic [31:0] res_nonce, hit_count;
    logic [2:0]  level;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    nonce_collector #(.DEPTH(DEPTH), .BLANK(BLANK)) dut (
        .clk      (clk),
        .reset    (reset),
        .job_start(job_start),
        .hit      (hit),
        .hit_nonce(hit_nonce),
        .res_valid(res_valid),
        .res_nonce(res_nonce),
        .res_ready(res_ready),
        .level    (level),
        .hit_count(hit_count),
        .overflow (overflow),
        .blanking (blanking)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Behavioural model: a queue of stored nonces plus plain counters
    logic [31:0] mq[$];
    logic [31:0] m_cnt  = 0;
    logic [31:0] m_last = 0;
    bit          m_ovf  = 0;
    int          m_bc   = 0;
    bit          m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete(); m_cnt = 0; m_ovf = 0; m_bc = 0; m_last = 0;
        end else if (job_start) begin
            mq.delete(); m_cnt = 0; m_ovf = 0; m_bc = BLANK;
        end else begin
            m_acc = (m_bc == 0) && hit;
            if (m_bc != 0) m_bc--;
            if (res_ready && mq.size() != 0) void'(mq.pop_front());
            if (m_acc) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (mq.size() < DEPTH) mq.push_back(hit_nonce);
                else m_ovf = 1;
            end
            if (mq.size() != 0) m_last = mq[0];
        end
    end

    always @(negedge clk) begin
        check("m_valid",    32'(res_valid), 32'(mq.size() != 0));
        check("m_nonce",    res_nonce,      m_last);
        check("m_level",    32'(level),     32'(mq.size()));
        check("m_count",    hit_count,      m_cnt);
        check("m_overflow", 32'(overflow),  32'(m_ovf));
        check("m_blanking", 32'(blanking),  32'(m_bc != 0));
    end

    task automatic check_zero(string tag);
        check({tag, "_valid"}, 32'(res_valid), 0);
        check({tag, "_nonce"}, res_nonce, 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_count"}, hit_count, 0);
        check({tag, "_ovf"},   32'(overflow), 0);
        check({tag, "_blank"}, 32'(blanking), 0);
    endtask

    int bl_cycles;
    int maxlev;

    initial begin
        reset = 1; job_start = 0; hit = 0; hit_nonce = 0; res_ready = 0;
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 0;

        // Reset then three hits
        for (int i = 0; i < 3; i++) begin
            hit = 1; hit_nonce = 32'h10 * (i + 1);
            @(negedge clk);
        end
        hit = 0;
        check("t1_level", 32'(level), 3);
        check("t1_valid", 32'(res_valid), 1);
        check("t1_nonce", res_nonce, 32'h10);
        check("t1_count", hit_count, 3);
        res_ready = 1;
        repeat (3) @(negedge clk);
        res_ready = 0;
        check("t1_drained", 32'(res_valid), 0);

        // Overflow
        job_start = 1;
        @(negedge clk);
        job_start = 0;
        repeat (BLANK) @(negedge clk);
        check("t2_run", 32'(blanking), 0);
        check("t2_cleared", hit_count, 0);
        for (int i = 0; i < 6; i++) begin
            hit = 1; hit_nonce = 32'hA0 + i;
            @(negedge clk);
        end
        hit = 0;
        check("t2_level", 32'(level), 4);
        check("t2_ovf", 32'(overflow), 1);
        check("t2_count", hit_count, 6);
        res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain", res_nonce, 32'hA0 + i);
            @(negedge clk);
        end
        res_ready = 0;
        check("t2_empty", 32'(res_valid), 0);

        // Blanking window
        job_start = 1;
        @(negedge clk);
        job_start = 0; hit = 1; hit_nonce = 32'h55;
        bl_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (blanking) bl_cycles++;
            @(negedge clk);
        end
        hit = 0;
        check("t3_blank_cycles", bl_cycles, 16);
        check("t3_level", 32'(level), 4);
        check("t3_count", hit_count, 4);
        check("t3_ovf", 32'(overflow), 0);

        // Full with simultaneous push and pop
        hit = 1; hit_nonce = 32'hBB; res_ready = 1;
        @(negedge clk);
        hit = 0; res_ready = 0;
        check("t4_level", 32'(level), 4);
        check("t4_ovf", 32'(overflow), 0);
        check("t4_count", hit_count, 5);
        res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("t4_drain", res_nonce, (i == 3) ? 32'hBB : 32'h55);
            @(negedge clk);
        end
        check("t4_empty", 32'(res_valid), 0);

        // Pointer wrap with res_ready held high
        maxlev = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            hit = 1; hit_nonce = 32'h100 + i;
            @(negedge clk);
            if (int'(level) > maxlev) maxlev = int'(level);
            check("t5_head", res_nonce, 32'h100 + i);
        end
        hit = 0;
        @(negedge clk);
        res_ready = 0;
        check("t5_maxlev", maxlev, 1);
        check("t5_level", 32'(level), 0);
        check("t5_count", hit_count, 17);

        // Flush with a coincident hit
        for (int i = 0; i < 2; i++) begin
            hit = 1; hit_nonce = 32'hC1 + i;
            @(negedge clk);
        end
        check("t6_pre_level", 32'(level), 2);
        job_start = 1; hit = 1; hit_nonce = 32'hDD;
        @(negedge clk);
        job_start = 0; hit = 0;
        check("t6_level", 32'(level), 0);
        check("t6_count", hit_count, 0);
        check("t6_valid", 32'(res_valid), 0);
        check("t6_hold", res_nonce, 32'hC1);
        check("t6_blank", 32'(blanking), 1);
        repeat (BLANK) @(negedge clk);
        check("t6_run", 32'(blanking), 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 2; i++) begin
            hit = 1; hit_nonce = 32'hE0 + i;
            @(negedge clk);
        end
        hit = 0;
        check("t7_pre_level", 32'(level), 2);
        @(posedge clk);
        #2 reset = 1;
        #1 check_zero("arst");
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
